// File: rtl/hdmi_period_sequencer_if.sv
// Bus between the HDMI period sequencer and its consumers.
// The sequencer (master) drives the timing position, syncs, period type,
// preamble control bits and data-island strobes. The packet source (slave)
// drives di_req.
//   di_req     packet source has an island packet ready (level)
//   hcount     pixel position within the line
//   vcount     line position within the frame
//   hsync      horizontal sync, active high
//   vsync      vertical sync, active high
//   vde        video data enable
//   mode       period type: 0 CTRL, 1 VID_GB, 2 VIDEO, 3 DI_GB, 4 DI_DATA
//   ctl        preamble bits {CTL3,CTL2,CTL1,CTL0}
//   di_grant   one-cycle pulse on the first preamble cycle of an island
//   di_active  high on the 32 island data cycles
//   di_idx     data cycle index 0..31 while di_active, else 0
interface hdmi_period_sequencer_if;
    logic        di_req;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        vde;
    logic [2:0]  mode;
    logic [3:0]  ctl;
    logic        di_grant;
    logic        di_active;
    logic [4:0]  di_idx;

    modport master (
        input  di_req,
        output hcount, vcount, hsync, vsync, vde, mode, ctl,
               di_grant, di_active, di_idx
    );

    modport slave (
        output di_req,
        input  hcount, vcount, hsync, vsync, vde, mode, ctl,
               di_grant, di_active, di_idx
    );
endinterface

// File: rtl/hdmi_period_sequencer.sv
// HDMI period sequencer: raster counters, syncs and the per-cycle period
// type (control, video guard band, video, island guard band, island data)
// including video preambles and at most one data island per line.
// Ports:
//   pixclk  pixel clock, all logic on its rising edge
//   rst     synchronous active-high reset
//   bus     hdmi_period_sequencer_if.master (di_req in, timing/period out)
// Every output is registered from the next-cycle position, so all outputs
// of a cycle describe the (hcount, vcount) presented in that same cycle.
//
// Island state machine:
//   state   | meaning
//   IDLE    | no island on this cycle
//   DI_PRE  | 8 preamble cycles, ctl 0101, grant on the first
//   DI_GB_L | 2 leading island guard-band cycles
//   DI_DATA | 32 island data cycles, di_idx 0..31
//   DI_GB_T | 2 trailing island guard-band cycles
module hdmi_period_sequencer #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int DI_OFFSET = 12
) (
    input  logic                      pixclk,
    input  logic                      rst,
    hdmi_period_sequencer_if.master   bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DI_P    = H_ACTIVE + DI_OFFSET;
    // Island (44 cycles) plus 12 control cycles must end before the video preamble.
    localparam bit DI_EN   = (DI_P + 44 + 12) <= (H_TOTAL - 10);

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT      = 11'(V_ACTIVE);
    localparam logic [10:0] H_SYNC_ON  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_OFF = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_SYNC_ON  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_OFF = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] H_PRE_ON   = 11'(H_TOTAL - 10);
    localparam logic [10:0] H_PRE_OFF  = 11'(H_TOTAL - 3);
    localparam logic [10:0] H_GB_ON    = 11'(H_TOTAL - 2);
    localparam logic [10:0] H_DI_DEC   = 11'(DI_P - 1);

    localparam logic [5:0] PH_PRE  = 6'd7;
    localparam logic [5:0] PH_GB   = 6'd1;
    localparam logic [5:0] PH_DATA = 6'd31;

    localparam logic [2:0] MODE_CTRL    = 3'd0;
    localparam logic [2:0] MODE_VID_GB  = 3'd1;
    localparam logic [2:0] MODE_VIDEO   = 3'd2;
    localparam logic [2:0] MODE_DI_GB   = 3'd3;
    localparam logic [2:0] MODE_DI_DATA = 3'd4;

    typedef enum logic [2:0] {IDLE, DI_PRE, DI_GB_L, DI_DATA, DI_GB_T} di_state_t;

    di_state_t   state_q, state_d;
    logic [5:0]  phase_q, phase_d;
    logic [10:0] h_q, v_q, h_d, v_d, v_after;
    logic        hsync_q, hsync_d, vsync_q, vsync_d, vde_q, vde_d;
    logic [2:0]  mode_q, mode_d;
    logic [3:0]  ctl_q, ctl_d;
    logic        grant_q, grant_d, active_q, active_d;
    logic [4:0]  idx_q, idx_d;

    // Next raster position and the line that follows it.
    always_comb begin
        h_d = h_q + 11'd1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 11'd1;
        end
        v_after = (v_d == V_LAST) ? '0 : v_d + 11'd1;
    end

    // Island FSM: phase is a down-counter, terminal count 0 advances state.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q - 6'd1;
        case (state_q)
            IDLE: begin
                phase_d = '0;
                if (DI_EN && h_q == H_DI_DEC && bus.di_req) begin
                    state_d = DI_PRE;
                    phase_d = PH_PRE;
                end
            end
            DI_PRE: begin
                if (phase_q == '0) begin
                    state_d = DI_GB_L;
                    phase_d = PH_GB;
                end
            end
            DI_GB_L: begin
                if (phase_q == '0) begin
                    state_d = DI_DATA;
                    phase_d = PH_DATA;
                end
            end
            DI_DATA: begin
                if (phase_q == '0) begin
                    state_d = DI_GB_T;
                    phase_d = PH_GB;
                end
            end
            DI_GB_T: begin
                if (phase_q == '0) begin
                    state_d = IDLE;
                    phase_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
            end
        endcase
    end

    // Output decode for the next position; video wins, then island, then preamble.
    always_comb begin
        mode_d   = MODE_CTRL;
        ctl_d    = '0;
        vde_d    = 1'b0;
        grant_d  = 1'b0;
        active_d = 1'b0;
        idx_d    = '0;
        hsync_d  = (h_d >= H_SYNC_ON) && (h_d < H_SYNC_OFF);
        vsync_d  = (v_d >= V_SYNC_ON) && (v_d < V_SYNC_OFF);
        if (h_d < H_ACT && v_d < V_ACT) begin
            mode_d = MODE_VIDEO;
            vde_d  = 1'b1;
        end else if (state_d != IDLE) begin
            case (state_d)
                DI_PRE: begin
                    ctl_d   = 4'b0101;
                    grant_d = (phase_d == PH_PRE);
                end
                DI_GB_L, DI_GB_T: mode_d = MODE_DI_GB;
                DI_DATA: begin
                    mode_d   = MODE_DI_DATA;
                    active_d = 1'b1;
                    // phase counts 31..0, so the index is its 5-bit complement
                    idx_d    = ~phase_d[4:0];
                end
                default: mode_d = MODE_CTRL;
            endcase
        end else if (v_after < V_ACT) begin
            if (h_d >= H_PRE_ON && h_d <= H_PRE_OFF) begin
                ctl_d = 4'b0001;
            end else if (h_d >= H_GB_ON) begin
                mode_d = MODE_VID_GB;
            end
        end
    end

    always_ff @(posedge pixclk) begin
        if (rst) begin
            h_q      <= '0;
            v_q      <= V_LAST;
            state_q  <= IDLE;
            phase_q  <= '0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            vde_q    <= 1'b0;
            mode_q   <= MODE_CTRL;
            ctl_q    <= '0;
            grant_q  <= 1'b0;
            active_q <= 1'b0;
            idx_q    <= '0;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            state_q  <= state_d;
            phase_q  <= phase_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            vde_q    <= vde_d;
            mode_q   <= mode_d;
            ctl_q    <= ctl_d;
            grant_q  <= grant_d;
            active_q <= active_d;
            idx_q    <= idx_d;
        end
    end

    assign bus.hcount    = h_q;
    assign bus.vcount    = v_q;
    assign bus.hsync     = hsync_q;
    assign bus.vsync     = vsync_q;
    assign bus.vde       = vde_q;
    assign bus.mode      = mode_q;
    assign bus.ctl       = ctl_q;
    assign bus.di_grant  = grant_q;
    assign bus.di_active = active_q;
    assign bus.di_idx    = idx_q;

endmodule

// File: tb/tb_hdmi_period_sequencer.sv
// Self-checking bench for hdmi_period_sequencer. A default-timing instance
// is exercised line by line from a scenario table; a small-timing instance
// (islands disabled by geometry) runs full frames alongside it.
module tb_hdmi_period_sequencer;

    typedef struct {
        int ha, hfp, hs, hbp, va, vfp, vs, vbp, dio;
    } cfg_t;

    typedef struct {
        int h;
        int v;
        bit isl;
    } mst_t;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        vde;
        logic [2:0]  mode;
        logic [3:0]  ctl;
        logic        grant;
        logic        active;
        logic [4:0]  idx;
    } obs_t;

    typedef struct {
        int line;
        int lo;
        int hi;
        int grants;
        int active;
        int gb;
        int grant_h;
    } line_vec_t;

    typedef struct {
        int         v;
        int         h;
        logic [2:0] mode;
        logic [3:0] ctl;
        logic       vde;
        logic       grant;
        logic       active;
        logic [4:0] idx;
    } spot_t;

    logic pixclk = 1'b0;
    logic rst    = 1'b1;
    logic rst_s  = 1'b1;
    always #5 pixclk = ~pixclk;

    hdmi_period_sequencer_if bus_m ();
    hdmi_period_sequencer_if bus_s ();

    hdmi_period_sequencer dut_m (
        .pixclk (pixclk),
        .rst    (rst),
        .bus    (bus_m.master)
    );

    hdmi_period_sequencer #(
        .H_ACTIVE(12), .H_FP(3), .H_SYNC(4), .H_BP(6),
        .V_ACTIVE(6),  .V_FP(2), .V_SYNC(2), .V_BP(2),
        .DI_OFFSET(4)
    ) dut_s (
        .pixclk (pixclk),
        .rst    (rst_s),
        .bus    (bus_s.master)
    );

    int n_pass  = 0;
    int n_total = 0;

    cfg_t  cfg_m, cfg_s;
    mst_t  st_m, st_s;
    obs_t  sb_m[$];
    obs_t  sb_s[$];
    spot_t spots[$];

    bit fr_on    = 1'b0;
    int fr_vde   = 0;
    int fr_vsync = 0;
    int fr_hsync = 0;
    int fr_count = 0;
    int s_grants = 0;

    task automatic chk(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, req);
    endtask

    task automatic chk_obs(input string name, input obs_t act, input obs_t req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s v%0d h%0d: got %h, want %h (hc vc hs vs de mode ctl gr act idx)",
                      name, req.vcount, req.hcount, act, req);
    endtask

    function automatic obs_t obs_m();
        obs_t o;
        o = '{bus_m.hcount, bus_m.vcount, bus_m.hsync, bus_m.vsync, bus_m.vde, bus_m.mode,
              bus_m.ctl, bus_m.di_grant, bus_m.di_active, bus_m.di_idx};
        return o;
    endfunction

    function automatic obs_t obs_s();
        obs_t o;
        o = '{bus_s.hcount, bus_s.vcount, bus_s.hsync, bus_s.vsync, bus_s.vde, bus_s.mode,
              bus_s.ctl, bus_s.di_grant, bus_s.di_active, bus_s.di_idx};
        return o;
    endfunction

    // Reference: position counters plus a per-line "island granted" flag;
    // period type is decoded from the raster position relative to the island start.
    task automatic model_step(input cfg_t c, inout mst_t s, input bit r, input bit q,
                              output obs_t e);
        int ht, vt, p, d, nl;
        bit en, g;
        ht = c.ha + c.hfp + c.hs + c.hbp;
        vt = c.va + c.vfp + c.vs + c.vbp;
        p  = c.ha + c.dio;
        en = (p + 56) <= (ht - 10);
        e  = '0;
        if (r) begin
            s.h = 0;
            s.v = vt - 1;
            s.isl = 1'b0;
            e.vcount = 11'(vt - 1);
            return;
        end
        g = en && (s.h == p - 1) && q;
        if (s.h == ht - 1) begin
            s.h = 0;
            s.v = (s.v == vt - 1) ? 0 : s.v + 1;
            s.isl = 1'b0;
        end else begin
            s.h = s.h + 1;
        end
        if (g) s.isl = 1'b1;
        e.hcount = 11'(s.h);
        e.vcount = 11'(s.v);
        e.hsync  = (s.h >= c.ha + c.hfp) && (s.h < c.ha + c.hfp + c.hs);
        e.vsync  = (s.v >= c.va + c.vfp) && (s.v < c.va + c.vfp + c.vs);
        nl = (s.v + 1) % vt;
        d  = s.h - p;
        if (s.h < c.ha && s.v < c.va) begin
            e.mode = 3'd2;
            e.vde  = 1'b1;
        end else if (s.isl && d >= 0 && d < 44) begin
            if (d < 8) begin
                e.ctl   = 4'b0101;
                e.grant = (d == 0);
            end else if (d < 10) begin
                e.mode = 3'd3;
            end else if (d < 42) begin
                e.mode   = 3'd4;
                e.active = 1'b1;
                e.idx    = 5'(d - 10);
            end else begin
                e.mode = 3'd3;
            end
        end else if (nl < c.va && s.h >= ht - 10 && s.h <= ht - 3) begin
            e.ctl = 4'b0001;
        end else if (nl < c.va && s.h >= ht - 2) begin
            e.mode = 3'd1;
        end
    endtask

    task automatic step(input bit r, input bit q);
        obs_t e, a;
        logic [14:0] got, want;
        rst = r;
        bus_m.di_req = q;
        bus_s.di_req = 1'b1;
        model_step(cfg_m, st_m, r, q, e);
        sb_m.push_back(e);
        model_step(cfg_s, st_s, rst_s, 1'b1, e);
        sb_s.push_back(e);
        @(posedge pixclk);
        #1;
        e = sb_m.pop_front();
        a = obs_m();
        chk_obs("main", a, e);
        if (!r) begin
            foreach (spots[i]) begin
                if (spots[i].v == int'(e.vcount) && spots[i].h == int'(e.hcount)) begin
                    got  = {a.mode, a.ctl, a.vde, a.grant, a.active, a.idx};
                    want = {spots[i].mode, spots[i].ctl, spots[i].vde, spots[i].grant,
                            spots[i].active, spots[i].idx};
                    chk($sformatf("spot v%0d h%0d {mode,ctl,vde,grant,act,idx}",
                                  spots[i].v, spots[i].h), int'(got), int'(want));
                end
            end
        end
        e = sb_s.pop_front();
        a = obs_s();
        chk_obs("small", a, e);
        s_grants += int'(a.grant);
        if (!rst_s && e.hcount == 11'd0 && e.vcount == 11'd0) begin
            if (fr_on) begin
                chk("small frame vde cycles", fr_vde, 72);
                chk("small frame vsync cycles", fr_vsync, 50);
                chk("small frame hsync cycles", fr_hsync, 48);
                fr_count++;
            end
            fr_on    = 1'b1;
            fr_vde   = 0;
            fr_vsync = 0;
            fr_hsync = 0;
        end
        if (fr_on) begin
            fr_vde   += int'(a.vde);
            fr_vsync += int'(a.vsync);
            fr_hsync += int'(a.hsync);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        line_vec_t lines[$];
        obs_t o;
        int guard, grants, act, gb, gh, bad;

        cfg_m = '{640, 16, 96, 48, 480, 10, 2, 33, 12};
        cfg_s = '{12, 3, 4, 6, 6, 2, 2, 2, 4};
        st_m  = '{0, 0, 1'b0};
        st_s  = '{0, 0, 1'b0};
        bus_m.di_req = 1'b0;
        bus_s.di_req = 1'b1;

        //          line lo   hi   grants active gb grant_h
        lines.push_back('{524, 0,   799, 1, 32, 4, 652});
        lines.push_back('{2,   0,   799, 1, 32, 4, 652});
        lines.push_back('{3,   652, 700, 0, 0,  0, -1});
        lines.push_back('{4,   640, 669, 1, 32, 4, 652});
        lines.push_back('{5,   651, 651, 1, 32, 4, 652});
        lines.push_back('{6,   650, 650, 0, 0,  0, -1});
        lines.push_back('{7,   0,   0,   0, 0,  0, -1});
        lines.push_back('{10,  0,   799, 1, 32, 4, 652});

        //               v    h    mode  ctl      vde   gr    act   idx
        spots.push_back('{524, 789, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0});
        spots.push_back('{524, 790, 3'd0, 4'b0001, 1'b0, 1'b0, 1'b0, 5'd0});
        spots.push_back('{524, 797, 3'd0, 4'b0001, 1'b0, 1'b0, 1'b0, 5'd0});
        spots.push_back('{524, 798, 3'd1, 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0});
        spots.push_back('{524, 799, 3'd1, 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0});
        spots.push_back('{0,   0,   3'd2, 4'b0000, 1'b1, 1'b0, 1'b0, 5'd0});
        spots.push_back('{0,   639, 3'd2, 4'b0000, 1'b1, 1'b0, 1'b0, 5'd0});
        spots.push_back('{0,   640, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0});
        spots.push_back('{0,   799, 3'd1, 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0});
        spots.push_back('{10,  651, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0});
        spots.push_back('{10,  652, 3'd0, 4'b0101, 1'b0, 1'b1, 1'b0, 5'd0});
        spots.push_back('{10,  659, 3'd0, 4'b0101, 1'b0, 1'b0, 1'b0, 5'd0});
        spots.push_back('{10,  660, 3'd3, 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0});
        spots.push_back('{10,  661, 3'd3, 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0});
        spots.push_back('{10,  662, 3'd4, 4'b0000, 1'b0, 1'b0, 1'b1, 5'd0});
        spots.push_back('{10,  693, 3'd4, 4'b0000, 1'b0, 1'b0, 1'b1, 5'd31});
        spots.push_back('{10,  694, 3'd3, 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0});
        spots.push_back('{10,  695, 3'd3, 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0});
        spots.push_back('{10,  696, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0});

        repeat (3) step(1'b1, 1'b0);
        o = obs_m();
        chk("reset hcount", int'(o.hcount), 0);
        chk("reset vcount", int'(o.vcount), 524);
        chk("reset mode", int'(o.mode), 0);
        chk("reset ctl", int'(o.ctl), 0);
        chk("reset vde/hsync/vsync", int'({o.vde, o.hsync, o.vsync}), 0);
        chk("reset grant/active/idx", int'({o.grant, o.active, o.idx}), 0);
        rst_s = 1'b0;

        foreach (lines[i]) begin
            guard = 0;
            while (!(st_m.h == 0 && st_m.v == lines[i].line) && guard <= 20000) begin
                step(1'b0, 1'b0);
                guard++;
            end
            chk($sformatf("reach line %0d within budget", lines[i].line), int'(guard <= 20000), 1);
            grants = 0; act = 0; gb = 0; gh = -1;
            for (int k = 0; k < 800; k++) begin
                step(1'b0, st_m.h >= lines[i].lo && st_m.h <= lines[i].hi);
                if (bus_m.di_grant) begin
                    grants++;
                    gh = int'(bus_m.hcount);
                end
                act += int'(bus_m.di_active);
                if (bus_m.mode == 3'd3) gb++;
            end
            chk($sformatf("line %0d grants", lines[i].line), grants, lines[i].grants);
            chk($sformatf("line %0d data cycles", lines[i].line), act, lines[i].active);
            chk($sformatf("line %0d island guard cycles", lines[i].line), gb, lines[i].gb);
            chk($sformatf("line %0d grant hcount", lines[i].line), gh, lines[i].grant_h);
        end

        // Reset in the middle of an island on line 12.
        guard = 0;
        while (!(st_m.h == 0 && st_m.v == 12) && guard <= 5000) begin
            step(1'b0, 1'b0);
            guard++;
        end
        while (st_m.h != 680 && guard <= 5000) begin
            step(1'b0, 1'b1);
            guard++;
        end
        chk("reach line 12 h680 within budget", int'(guard <= 5000), 1);
        chk("island data before reset", int'(bus_m.di_active), 1);
        step(1'b1, 1'b1);
        o = obs_m();
        chk("mid-island reset hcount", int'(o.hcount), 0);
        chk("mid-island reset vcount", int'(o.vcount), 524);
        chk("mid-island reset mode", int'(o.mode), 0);
        chk("mid-island reset ctl/grant", int'({o.ctl, o.grant}), 0);
        chk("mid-island reset active/idx", int'({o.active, o.idx}), 0);
        bad = 0;
        for (int k = 0; k < 60; k++) begin
            step(1'b0, 1'b0);
            if (bus_m.mode == 3'd3 || bus_m.mode == 3'd4 || bus_m.di_active) bad++;
        end
        chk("no island cycles after reset", bad, 0);

        chk("small timing never grants", s_grants, 0);
        chk("small frames observed >= 3", int'(fr_count >= 3), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hdmi_period_sequencer.md
HDMI_PERIOD_SEQUENCER -- requirements
Module: hdmi_period_sequencer

Interface
REQ-001 Parameters (name, default, meaning): H_ACTIVE 640 active pixels; H_FP 16 front porch; H_SYNC 96 hsync width; H_BP 48 back porch; V_ACTIVE 480 lines; V_FP 10; V_SYNC 2; V_BP 33; DI_OFFSET 12 control cycles between active-video end and data-island preamble.
REQ-002 Derived: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
REQ-003 Ports (name, direction, width, meaning): pixclk in 1 pixel clock; one clock, all logic on its rising edge.
REQ-004 rst in 1 synchronous active-high reset.
REQ-005 di_req in 1 data-island request, level; packet source has a packet ready.
REQ-006 hcount out 11 pixel counter; vcount out 11 line counter.
REQ-007 hsync out 1, vsync out 1; both active-high.
REQ-008 vde out 1 video data enable; high only in mode VIDEO.
REQ-009 mode out 3 per-cycle period type: 0 CTRL, 1 VID_GB, 2 VIDEO, 3 DI_GB, 4 DI_DATA.
REQ-010 ctl out 4 preamble bits {CTL3,CTL2,CTL1,CTL0}; 0 outside preambles.
REQ-011 di_grant out 1 one-cycle pulse on first preamble cycle of a granted island.
REQ-012 di_active out 1 high on the 32 DI_DATA cycles; di_idx out 5 index 0..31 in those cycles, else 0.

Function
REQ-013 All outputs SHALL be registered and mutually aligned: each cycle's outputs describe position (hcount, vcount).
REQ-014 hcount SHALL count 0..H_TOTAL-1 and wrap to 0; vcount SHALL increment only on hcount wrap, counting 0..V_TOTAL-1, wrapping to 0.
REQ-015 hsync SHALL be 1 iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (656..751).
REQ-016 vsync SHALL be 1 iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (490..491), for the whole line.
REQ-017 mode VIDEO SHALL occur iff hcount < H_ACTIVE and vcount < V_ACTIVE.
REQ-018 Video preamble: when next line ((vcount+1) mod V_TOTAL) < V_ACTIVE, hcount H_TOTAL-10..H_TOTAL-3 SHALL give mode CTRL, ctl 4'b0001; hcount H_TOTAL-2..H_TOTAL-1 SHALL give mode VID_GB.
REQ-019 No video preamble/guard band when next line is blanking (e.g. end of line 479).
REQ-020 Island decision: di_req sampled at the edge that leaves hcount = H_ACTIVE+DI_OFFSET-1, on every line (active or blanking).
REQ-021 If sampled 1: hcount P..P+7 (P = H_ACTIVE+DI_OFFSET) mode CTRL, ctl 4'b0101, di_grant=1 at P only; P+8..P+9 DI_GB; P+10..P+41 DI_DATA, di_active=1, di_idx = hcount-(P+10); P+42..P+43 DI_GB; then CTRL.
REQ-022 If sampled 0: no island that line; di_req at any other hcount SHALL be ignored.
REQ-023 Max one island per line; a started island SHALL complete regardless of di_req.
REQ-024 Islands SHALL be disabled (di_grant never asserted) if P+44+12 > H_TOTAL-10.
REQ-025 All remaining cycles SHALL be mode CTRL, ctl 0.
REQ-026 Island phases SHALL come from a state machine (IDLE, DI_PRE, DI_GB_L, DI_DATA, DI_GB_T) with a 6-bit phase counter, not from hcount decode alone.

Reset
REQ-027 While rst=1 at an edge, next outputs SHALL be: hcount 0, vcount V_TOTAL-1, mode CTRL, ctl 0, vde 0, di_grant 0, di_active 0, di_idx 0, hsync 0, vsync 0; island FSM IDLE.
REQ-028 rst mid-island SHALL abort it immediately; no DI_GB/DI_DATA after reset.
REQ-029 Counting SHALL resume from the reset position on the first edge with rst=0, so line 0 is preceded by a video preamble.

Verification
REQ-030 Reset release: vcount 524, hcount 0 -> ctl 0001 at hcount 790..797, VID_GB 798..799, then vcount 0 hcount 0 mode VIDEO, vde 1.
REQ-031 Free-run one frame: hsync high hcount 656..751 every line; vsync high lines 490..491 only; vde count = 307200.
REQ-032 di_req held 1 on line 10: di_grant at 652; ctl 0101 at 652..659; DI_GB 660..661; DI_DATA 662..693, di_idx 0..31; DI_GB 694..695; CTRL at 696.
REQ-033 di_req 1 only at hcount 652..700 -> no island that line; di_req dropped at hcount 670 after grant -> island completes through 695.
REQ-034 rst pulsed at hcount 680 during island -> next cycle REQ-027 values, di_active 0, no trailing guard band.
REQ-035 End of line 479: no preamble, mode CTRL at 790..799; end of line 524: preamble present.
